// File: rtl/mont_mul_seq258_if.sv
// Host-side start/done handshake of the Montgomery multiply sequencer.
// master = modular-arithmetic host, slave = mont_mul_seq258.
interface mont_mul_seq258_if;
    logic         start;
    logic [257:0] a;
    logic [257:0] b;
    logic [257:0] n;
    logic [257:0] n_prime;
    logic         busy;
    logic         done;
    logic [257:0] res;

    modport master (output start, a, b, n, n_prime, input busy, done, res);
    modport slave  (input start, a, b, n, n_prime, output busy, done, res);
endinterface

// File: rtl/mont_mul_seq258.sv
// Montgomery product res = a*b*R^-1 mod n, time-sharing one external registered
// multiplier across the three reduction multiplies, then add/shift and final subtract.
module mont_mul_seq258 #(
    parameter int R_BITS  = 256,
    parameter int MUL_LAT = 4
) (
    input  logic               clk,
    input  logic               rst,
    mont_mul_seq258_if.slave   host,
    output logic [257:0]       mul_a,
    output logic [257:0]       mul_b,
    input  logic [515:0]       mul_p
);

    localparam int W  = 258;
    localparam int PW = 516;
    localparam int CW = 8;

    typedef enum logic [2:0] {
        S_IDLE,
        S_MUL1,
        S_MUL2,
        S_MUL3,
        S_ADD,
        S_SUB,
        S_DONE
    } state_t;

    state_t            state;
    logic [CW-1:0]     cnt;
    logic [W-1:0]      n_r;
    logic [R_BITS-1:0] np_r;
    logic [PW-1:0]     t_r;
    logic [PW-1:0]     p_r;
    logic [W-1:0]      u_r;
    logic              last;

    assign last = (cnt == CW'(MUL_LAT));

    // mul_a/mul_b double as the latched a/b and, during MUL3, as the m register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= S_IDLE;
            cnt       <= '0;
            n_r       <= '0;
            np_r      <= '0;
            t_r       <= '0;
            p_r       <= '0;
            u_r       <= '0;
            mul_a     <= '0;
            mul_b     <= '0;
            host.busy <= 1'b0;
            host.done <= 1'b0;
            host.res  <= '0;
        end else begin
            host.done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (host.start) begin
                        mul_a     <= host.a;
                        mul_b     <= host.b;
                        n_r       <= host.n;
                        np_r      <= R_BITS'(host.n_prime);
                        cnt       <= '0;
                        host.busy <= 1'b1;
                        state     <= S_MUL1;
                    end
                end
                S_MUL1: begin
                    if (last) begin
                        t_r   <= mul_p;
                        mul_a <= W'(R_BITS'(mul_p));
                        mul_b <= W'(np_r);
                        cnt   <= '0;
                        state <= S_MUL2;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                S_MUL2: begin
                    if (last) begin
                        mul_a <= W'(R_BITS'(mul_p));
                        mul_b <= n_r;
                        cnt   <= '0;
                        state <= S_MUL3;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                S_MUL3: begin
                    if (last) begin
                        p_r   <= mul_p;
                        mul_a <= '0;
                        mul_b <= '0;
                        cnt   <= '0;
                        state <= S_ADD;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                S_ADD: begin
                    // low R_BITS of the 517-bit sum are zero by choice of m
                    u_r   <= W'(({1'b0, t_r} + {1'b0, p_r}) >> R_BITS);
                    state <= S_SUB;
                end
                S_SUB: begin
                    host.res  <= (u_r >= n_r) ? (u_r - n_r) : u_r;
                    host.done <= 1'b1;
                    state     <= S_DONE;
                end
                S_DONE: begin
                    host.busy <= 1'b0;
                    state     <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
